// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: circular FIFO between fetch and decode.
// Define IFETCH_BUF_BYPASS_EN to add an empty-buffer enq->deq bypass.
module ifetch_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [51:0]              enq_instr,
  input  logic [AW-1:0]            enq_pc,
  input  logic                     enq_predict_taken,
  output logic                     enq_ready,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [51:0]              deq_instr,
  output logic [AW-1:0]            deq_pc,
  output logic                     deq_predict_taken,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [51:0]   instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];
  logic          pred_mem  [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic empty;
  logic enq_fire;
  logic deq_fire;
  logic wr_en;
  logic rd_en;

  assign empty     = (count_q == '0);
  assign enq_ready = (count_q < CW'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign deq_fire  = deq_valid && deq_ready && !flush;
  assign count     = count_q;

`ifdef IFETCH_BUF_BYPASS_EN
  logic byp_taken;

  // When empty, the offered entry is presented directly; if consumed it never hits storage.
  always_comb begin
    deq_valid         = !empty;
    deq_instr         = instr_mem[head_q];
    deq_pc            = pc_mem[head_q];
    deq_predict_taken = pred_mem[head_q];
    if (empty && !flush) begin
      deq_valid         = enq_valid;
      deq_instr         = enq_instr;
      deq_pc            = enq_pc;
      deq_predict_taken = enq_predict_taken;
    end
  end

  assign byp_taken = empty && enq_fire && deq_fire;
  assign wr_en     = enq_fire && !byp_taken;
  assign rd_en     = deq_fire && !byp_taken;
`else
  always_comb begin
    deq_valid         = !empty;
    deq_instr         = instr_mem[head_q];
    deq_pc            = pc_mem[head_q];
    deq_predict_taken = pred_mem[head_q];
  end

  assign wr_en = enq_fire;
  assign rd_en = deq_fire;
`endif

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PW'(1);
      if (rd_en) head_d = head_q + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      instr_mem[tail_q] <= enq_instr;
      pc_mem[tail_q]    <= enq_pc;
      pred_mem[tail_q]  <= enq_predict_taken;
    end
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed self-checking bench for ifetch_buf (DEPTH=4, AW=32).
module tb_ifetch_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        enq_valid;
  logic [51:0] enq_instr;
  logic [31:0] enq_pc;
  logic        enq_predict_taken;
  logic        enq_ready;
  logic        deq_valid;
  logic        deq_ready;
  logic [51:0] deq_instr;
  logic [31:0] deq_pc;
  logic        deq_predict_taken;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  ifetch_buf #(.DEPTH(4), .AW(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .enq_valid         (enq_valid),
    .enq_instr         (enq_instr),
    .enq_pc            (enq_pc),
    .enq_predict_taken (enq_predict_taken),
    .enq_ready         (enq_ready),
    .deq_valid         (deq_valid),
    .deq_ready         (deq_ready),
    .deq_instr         (deq_instr),
    .deq_pc            (deq_pc),
    .deq_predict_taken (deq_predict_taken),
    .count             (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
  endtask

  // Entry fields are derived from the instr value so pc/prediction can be checked too.
  task automatic set_enq(input logic [51:0] ins);
    enq_instr         = ins;
    enq_pc            = 32'h100 + ins[31:0] * 4;
    enq_predict_taken = ins[0];
  endtask

  task automatic push(input logic [51:0] ins);
    enq_valid = 1'b1;
    set_enq(ins);
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    set_enq(52'h0);
    do_reset();
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", count);
    end
    checks++;
    if (deq_valid !== 1'b0) begin
      errors++; $display("FAIL reset_deq_valid got %b want 0", deq_valid);
    end
    checks++;
    if (enq_ready !== 1'b1) begin
      errors++; $display("FAIL reset_enq_ready got %b want 1", enq_ready);
    end
  endtask

  task automatic test_fill();
    push(52'h1); push(52'h2); push(52'h3);
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL fill_count got %0d want 3", count);
    end
    checks++;
    if (deq_valid !== 1'b1 || deq_instr !== 52'h1) begin
      errors++; $display("FAIL fill_head got v=%b %h want v=1 1", deq_valid, deq_instr);
    end
    checks++;
    if (enq_ready !== 1'b1) begin
      errors++; $display("FAIL fill_enq_ready got %b want 1", enq_ready);
    end
  endtask

  task automatic test_full();
    push(52'h4);
    checks++;
    if (count !== 3'd4 || enq_ready !== 1'b0) begin
      errors++; $display("FAIL full_state got cnt=%0d rdy=%b want cnt=4 rdy=0", count, enq_ready);
    end
    push(52'h5);
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL full_overflow_count got %0d want 4", count);
    end
    deq_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (deq_valid !== 1'b1 || deq_instr !== 52'(k) || deq_pc !== 32'(32'h100 + k * 4)
          || deq_predict_taken !== k[0]) begin
        errors++;
        $display("FAIL full_pop%0d got v=%b i=%h pc=%h p=%b want instr %0d", k, deq_valid,
                 deq_instr, deq_pc, deq_predict_taken, k);
      end
      tick();
    end
    deq_ready = 1'b0;
    checks++;
    if (deq_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL full_drained got v=%b cnt=%0d want v=0 cnt=0", deq_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(52'd10); push(52'd11); push(52'd12);
    for (int i = 0; i < 8; i++) begin
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      set_enq(52'(13 + i));
      checks++;
      if (count !== 3'd3 || deq_instr !== 52'(10 + i)) begin
        errors++;
        $display("FAIL b2b_step%0d got cnt=%0d i=%0d want cnt=3 i=%0d", i, count, deq_instr,
                 10 + i);
      end
      tick();
    end
    enq_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (deq_valid !== 1'b1 || deq_instr !== 52'(18 + i) || deq_pc !== 32'(32'h100 + (18 + i) * 4)) begin
        errors++;
        $display("FAIL b2b_drain%0d got v=%b i=%0d want i=%0d", i, deq_valid, deq_instr, 18 + i);
      end
      tick();
    end
    deq_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL b2b_final_count got %0d want 0", count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    push(52'd30); push(52'd31);
    flush     = 1'b1;
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    set_enq(52'd32);
    tick();
    idle();
    checks++;
    if (count !== 3'd0 || deq_valid !== 1'b0) begin
      errors++; $display("FAIL flush_state got cnt=%0d v=%b want cnt=0 v=0", count, deq_valid);
    end
    push(52'd33);
    checks++;
    if (count !== 3'd1 || deq_instr !== 52'd33) begin
      errors++; $display("FAIL flush_after got cnt=%0d i=%0d want cnt=1 i=33", count, deq_instr);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    enq_valid         = 1'b1;
    enq_instr         = 52'd40;
    enq_pc            = 32'h0000_1000;
    enq_predict_taken = 1'b1;
    deq_ready         = 1'b1;
    #1;
    checks++;
`ifdef IFETCH_BUF_BYPASS_EN
    if (deq_valid !== 1'b1 || deq_pc !== 32'h1000 || deq_predict_taken !== 1'b1) begin
      errors++;
      $display("FAIL bypass_same_cycle got v=%b pc=%h p=%b want 1 1000 1", deq_valid, deq_pc,
               deq_predict_taken);
    end
`else
    if (deq_valid !== 1'b0) begin
      errors++; $display("FAIL bypass_same_cycle got v=%b want 0", deq_valid);
    end
`endif
    tick();
    idle();
    checks++;
`ifdef IFETCH_BUF_BYPASS_EN
    if (count !== 3'd0 || deq_valid !== 1'b0) begin
      errors++; $display("FAIL bypass_next got cnt=%0d v=%b want cnt=0 v=0", count, deq_valid);
    end
`else
    if (count !== 3'd1 || deq_valid !== 1'b1 || deq_pc !== 32'h1000
        || deq_predict_taken !== 1'b1) begin
      errors++;
      $display("FAIL bypass_next got cnt=%0d v=%b pc=%h p=%b want 1 1 1000 1", count, deq_valid,
               deq_pc, deq_predict_taken);
    end
`endif
  endtask

  task automatic test_reset_full();
    do_reset();
    push(52'd50); push(52'd51); push(52'd52); push(52'd53);
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL rstfull_pre got %0d want 4", count);
    end
    // Reset must win over a concurrent dequeue and flush.
    rst_n     = 1'b0;
    deq_ready = 1'b1;
    flush     = 1'b1;
    tick();
    rst_n = 1'b1;
    idle();
    checks++;
    if (count !== 3'd0 || enq_ready !== 1'b1 || deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstfull_post got cnt=%0d rdy=%b v=%b want 0 1 0", count, enq_ready,
               deq_valid);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_full();
    test_back_to_back();
    test_flush();
    test_bypass();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_buf.md
IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, meaning number of FIFO entries (power of two, 2..16).
REQ-002 The block SHALL expose parameter AW, default 32, meaning program-counter width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, which is the reset: synchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1, which discards all queued entries (branch miss or exception).
REQ-006 The block SHALL have port enq_valid, input, 1, which marks a fetched instruction as offered.
REQ-007 The block SHALL have port enq_instr, input, 52, which carries the raw instruction; bits [6:0] are the opcode.
REQ-008 The block SHALL have port enq_pc, input, AW, which carries the instruction address.
REQ-009 The block SHALL have port enq_predict_taken, input, 1, which carries the fetch-stage branch prediction.
REQ-010 The block SHALL have port enq_ready, output, 1, which indicates the buffer can accept an entry this cycle.
REQ-011 The block SHALL have port deq_valid, output, 1, which indicates the head entry is presented to the decoder.
REQ-012 The block SHALL have port deq_ready, input, 1, which indicates the decoder consumes the head this cycle.
REQ-013 The block SHALL have output ports deq_instr (52), deq_pc (AW) and deq_predict_taken (1), which carry the head entry fields driving the decoder's instr and predict_taken inputs.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1, which gives the current occupancy.

Function
REQ-015 An enqueue SHALL occur on a rising edge with enq_valid && enq_ready && !flush; a dequeue SHALL occur with deq_valid && deq_ready && !flush.
REQ-016 enq_ready SHALL equal (count < DEPTH), derived from registered state only, with no combinational path from deq_ready.
REQ-017 deq_valid SHALL equal (count != 0) when the bypass is absent.
REQ-018 Storage SHALL be a circular buffer with head/tail pointers of width $clog2(DEPTH), wrapping DEPTH-1 -> 0 modulo DEPTH.
REQ-019 A simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers, including when count==DEPTH-1 and when count==1.
REQ-020 count SHALL increment on enqueue-only, decrement on dequeue-only, and never exceed DEPTH or go below 0.
REQ-021 flush SHALL set count, head and tail to 0 on that edge, discarding any same-cycle enqueue and dequeue; deq_valid SHALL be 0 the following cycle.
REQ-022 Entry fields SHALL be returned bit-exact in FIFO order.
REQ-023 deq_* data SHALL hold stable while deq_valid && !deq_ready.
REQ-024 deq_* data SHALL be don't-care when deq_valid==0; the bench SHALL NOT check it.
REQ-025 Latency SHALL be: without bypass, an entry enqueued at edge N is presented at deq from cycle N+1.

Reset
REQ-026 While rst_n==0 at a rising edge, head, tail and count SHALL become 0, so deq_valid=0, enq_ready=1 and count=0 the next cycle.
REQ-027 Reset SHALL take priority over flush, enqueue and dequeue; an operation in flight during reset is discarded.
REQ-028 Storage array contents SHALL NOT be reset.

Configuration
REQ-029 Macro IFETCH_BUF_BYPASS_EN SHALL control the empty-buffer bypass.
REQ-030 With IFETCH_BUF_BYPASS_EN defined: when count==0 and !flush, deq_valid SHALL equal enq_valid and deq_* SHALL equal enq_* combinationally.
REQ-031 With IFETCH_BUF_BYPASS_EN defined: if the bypass entry is also dequeued that cycle, it SHALL NOT be written to storage and count SHALL remain 0.
REQ-032 Without IFETCH_BUF_BYPASS_EN, there SHALL be no combinational enq->deq path and latency SHALL be as in REQ-025.

Verification
REQ-033 The bench SHALL cover this scenario: reset, then push instr 52'h0000_0000_0001, 52'h...0002, 52'h...0003 with deq_ready=0 -> count=3, deq_instr=1, enq_ready=1.
REQ-034 The bench SHALL cover this scenario: DEPTH=4, push 4 entries, offer a 5th -> enq_ready=0, 5th not stored; then pop 4 -> order 1,2,3,4 and deq_valid=0.
REQ-035 The bench SHALL cover this scenario: count=3, enqueue and dequeue together for 8 cycles -> count stays 3, pointers wrap twice, order preserved.
REQ-036 The bench SHALL cover this scenario: count=2, flush asserted together with enq_valid and deq_ready -> next cycle count=0, deq_valid=0, neither entry consumed nor stored.
REQ-037 The bench SHALL cover this scenario: bypass build, empty buffer, enq_valid=1 with pc=32'h0000_1000, predict_taken=1, deq_ready=1 -> same cycle deq_valid=1, deq_pc=32'h1000, deq_predict_taken=1, count stays 0; non-bypass build -> deq_valid=1 the next cycle with count=1.
REQ-038 The bench SHALL cover this scenario: rst_n=0 held one edge with count=4 -> count=0, enq_ready=1, deq_valid=0.
